// File: rtl/dmem_responder.sv
// Data-memory responder: byte-lane word RAM plus LED/counter/status window.
// Define DMEM_STORE_COUNT_EN to enable the accepted-RAM-store counter.
module dmem_responder #(
    parameter int          DEPTH     = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hF000_0000,
    parameter int          LED_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_w,
    input  logic [3:0]       wea,
    input  logic [31:0]      Addr_in,
    input  logic [31:0]      Data_in,
    input  logic [2:0]       DMType,
    output logic [31:0]      Data_out,
    output logic             MIO_ready,
    output logic [LED_W-1:0] led_out,
    output logic             err_irq
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          ram_hit;
    logic          mmio_hit;
    logic          misaligned;
    logic          store_ok;
    logic          set_mis;
    logic          set_rng;
    logic          clr_mis;
    logic          clr_rng;
    logic          misalign_err;
    logic          range_err;
    logic [31:0]   cyc_cnt;
    logic [31:0]   st_cnt;

    assign idx      = Addr_in[AW+1:2];
    assign ram_hit  = ({2'b00, Addr_in[31:2]} < 32'(DEPTH));
    assign mmio_hit = ~ram_hit && (Addr_in[31:4] == MMIO_BASE[31:4]);

    // Alignment check by access size, only meaningful for stores
    always_comb begin
        misaligned = 1'b0;
        case (DMType)
            3'b000:         misaligned = (Addr_in[1:0] != 2'b00);
            3'b001, 3'b010: misaligned = Addr_in[0];
            default:        misaligned = 1'b0;
        endcase
        misaligned = misaligned & mem_w;
    end

    assign store_ok = mem_w & ~reset & ~misaligned;
    assign set_mis  = misaligned;
    assign set_rng  = store_ok & ~ram_hit & ~mmio_hit;
    assign clr_mis  = store_ok & mmio_hit & (Addr_in[3:2] == 2'b10) & Data_in[0];
    assign clr_rng  = store_ok & mmio_hit & (Addr_in[3:2] == 2'b10) & Data_in[1];

    // Byte-lane RAM write; contents survive reset
    always_ff @(posedge clk) begin
        if (store_ok && ram_hit) begin
            for (int i = 0; i < 4; i++) begin
                if (wea[i]) mem[idx][8*i +: 8] <= Data_in[8*i +: 8];
            end
        end
    end

    // LED, status bits (set wins over W1C) and free-running cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            led_out      <= '0;
            misalign_err <= 1'b0;
            range_err    <= 1'b0;
            cyc_cnt      <= '0;
        end else begin
            cyc_cnt      <= cyc_cnt + 32'd1;
            misalign_err <= set_mis | (misalign_err & ~clr_mis);
            range_err    <= set_rng | (range_err & ~clr_rng);
            if (store_ok && mmio_hit && Addr_in[3:2] == 2'b00 && (wea[0] || wea[1]))
                led_out <= Data_in[LED_W-1:0];
        end
    end

`ifdef DMEM_STORE_COUNT_EN
    // Count accepted RAM stores that actually touch a byte lane
    always_ff @(posedge clk) begin
        if (reset)
            st_cnt <= '0;
        else if (store_ok && ram_hit && wea != 4'b0000)
            st_cnt <= st_cnt + 32'd1;
    end
`else
    assign st_cnt = '0;
`endif

    // Zero-latency read mux
    always_comb begin
        Data_out = '0;
        if (ram_hit) begin
            Data_out = mem[idx];
        end else if (mmio_hit) begin
            case (Addr_in[3:2])
                2'b00:   Data_out = 32'(led_out);
                2'b01:   Data_out = cyc_cnt;
                2'b10:   Data_out = {30'b0, range_err, misalign_err};
                default: Data_out = st_cnt;
            endcase
        end
    end

    assign MIO_ready = 1'b1;
    assign err_irq   = misalign_err | range_err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory-side responder for the pipelined CPU's DM port.
- Accepts the CPU's MEM-stage signals (mem_w, wea, address, write data, DMType) and returns a raw aligned 32-bit word.
- Contains a byte-lane-writable word RAM plus a small memory-mapped register window: LED register, free-running cycle counter, sticky error status.
- The CPU does all sub-word extraction and sign extension itself from the returned word and Addr[1:0].

Parameters:
- DEPTH, 1024, number of 32-bit RAM words; RAM occupies byte addresses 0 .. 4*DEPTH-1.
- MMIO_BASE, 32'hF000_0000, base byte address of the register window; decoded on Addr_in[31:4] == MMIO_BASE[31:4].
- LED_W, 16, width of the LED register.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous reset, active-high.
- mem_w  input  1  store request for the current cycle.
- wea  input  4  byte-lane write enables, already shifted to lane position by the CPU.
- Addr_in  input  32  byte address (CPU ALU output).
- Data_in  input  32  store data, already lane-positioned.
- DMType  input  3  access size: 000 word, 001 half, 010 half-unsigned, 011 byte, 100 byte-unsigned.
- Data_out  output  32  raw aligned read word, to the CPU Data_in.
- MIO_ready  output  1  constant 1; no wait states.
- led_out  output  LED_W  LED register.
- err_irq  output  1  OR of the sticky status bits.

Behaviour:
- Reset:
  - At a rising clk edge with reset=1, led_out, status, the cycle counter and the store counter all go to 0.
  - All writes are suppressed in that cycle, RAM included.
  - RAM contents are not cleared.
- Read path (combinational, zero latency):
  - RAM hit: Data_out = RAM[Addr_in[31:2]].
  - MMIO hit, by Addr_in[3:2]:
    - 00: LED, zero-extended.
    - 01: cycle counter.
    - 10: {30'b0, range_err, misalign_err}.
    - 11: store counter.
  - Otherwise: Data_out = 0.
- Misalignment:
  - misaligned = (DMType==000 and Addr_in[1:0]!=0) or (DMType in {001,010} and Addr_in[0]!=0).
  - Evaluated only when mem_w=1.
  - A misaligned store writes nothing and sets misalign_err on the next edge.
- Store (mem_w=1, not misaligned, reset=0), applied at the rising edge:
  - RAM hit: for each i with wea[i]=1, RAM byte lane i <= Data_in[8i+7:8i]. wea=0000 is a legal no-op.
  - MMIO offset 00: led_out <= Data_in[LED_W-1:0] if wea[0] or wea[1] is set.
  - MMIO offset 01: ignored (read-only).
  - MMIO offset 10: write-1-to-clear; bit0 clears misalign_err if Data_in[0]=1, bit1 clears range_err if Data_in[1]=1.
  - MMIO offset 11: ignored.
  - Neither RAM nor MMIO: no write; range_err sets.
- Loads (mem_w=0) never set error bits, even when misaligned or out of range.
- Set/clear collision: a W1C clear and a new error in the same cycle leave the bit set (set wins).
- Cycle counter: 32-bit, +1 every non-reset cycle, wraps FFFF_FFFF -> 0.
- Same-cycle read and write to the same address: Data_out shows the old value; the new value is visible from the next cycle.
- err_irq = misalign_err | range_err, registered-bit OR with no extra latency.

Optional Feature:
- Macro DMEM_STORE_COUNT_EN.
- Defined:
  - The store counter (MMIO offset 11) is a 32-bit wrapping counter.
  - It increments by 1 on each accepted RAM store (RAM hit, aligned, wea != 0000).
  - MMIO stores and rejected stores do not count.
- Undefined: no counter register; offset 11 reads 0.

Test Plan:
- Reset, then word store 0xDEADBEEF to 0x0000_0010 with wea=1111, DMType=000 -> next cycle, read of 0x10 returns 0xDEADBEEF.
- Byte store Data_in=0x0000_5500, wea=0010, addr 0x11, DMType=011 over 0xDEADBEEF -> word reads 0xDEAD55EF.
- Word store to 0x0000_0012 (DMType=000) -> RAM unchanged; misalign_err=1, err_irq=1. Then store 0x1 to MMIO_BASE+8 -> misalign_err=0.
- Store to 0x0001_0000 with DEPTH=1024 -> range_err=1, read of that address returns 0. A W1C clear coinciding with another out-of-range store -> range_err stays 1.
- Store 0x0000_A5A5 to MMIO_BASE+0 -> led_out=0xA5A5. Reads of MMIO_BASE+4 taken 10 cycles apart differ by exactly 10. Assert reset -> led_out=0, counter=0, but RAM[0x10] still reads 0xDEADBEEF.
- With DMEM_STORE_COUNT_EN: 3 accepted RAM stores, 1 misaligned store, 1 MMIO store -> MMIO_BASE+C reads 3. Without the macro it reads 0.
